instr_mem_pipe: RTL



---
 rtl/instr_mem_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_mem_pipe.sv
// Byte-addressed, big-endian instruction store with a registered valid/ready fetch
// path, a byte-enabled program-load port, alignment/range faults and a fetch counter.
module instr_mem_pipe #(
  parameter int XLEN = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                flush,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_inst,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic [1:0]          rsp_fault,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [XLEN-1:0]     load_data,
  input  logic [XLEN/8-1:0]   load_be,
  output logic [31:0]         fetch_count
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD_A = ADDR_W'(DEPTH_BYTES - BYTES);

  logic [7:0]        mem_q [DEPTH_BYTES];

  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_inst_q, rsp_inst_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic [1:0]        fault_code;
  logic [XLEN-1:0]   rd_word;
  logic [BYTES-1:0]  wr_be;
  logic [IDX_W-1:0]  wr_base;

  assign req_ready = !flush && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Fetch-side read: memory is read before this edge's load lands, giving read-first.
  always_comb begin
    rd_word      = NOP_INST;
    misaligned   = |req_addr[OFF_W-1:0];
    out_of_range = req_addr > LAST_WORD_A;
    if (misaligned) begin
      fault_code = 2'b01;
    end else if (out_of_range) begin
      fault_code = 2'b10;
    end else begin
      fault_code = 2'b00;
      for (int i = 0; i < BYTES; i++) begin
        rd_word[XLEN-1-8*i -: 8] = mem_q[req_addr[IDX_W-1:0] + IDX_W'(i)];
      end
    end
  end

  always_comb begin
    wr_base = {load_addr[IDX_W-1:OFF_W], {OFF_W{1'b0}}};
    if (load_en && !reset && (load_addr < DEPTH_A)) begin
      wr_be = load_be;
    end else begin
      wr_be = {BYTES{1'b0}};
    end
  end

  // Storage is deliberately not reset; load_be MSB maps to the lowest byte address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (wr_be[BYTES-1-i]) begin
        mem_q[wr_base + IDX_W'(i)] <= load_data[XLEN-1-8*i -: 8];
      end
    end
  end

  // Flush wins over accept; a held response persists only while stalled.
  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_inst_d    = rsp_inst_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_fault_d   = rsp_fault_q;
    fetch_count_d = fetch_count_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_inst_d    = rd_word;
      rsp_addr_d    = req_addr;
      rsp_fault_d   = fault_code;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_inst_q    <= NOP_INST;
      rsp_addr_q    <= {ADDR_W{1'b0}};
      rsp_fault_q   <= 2'b00;
      fetch_count_q <= 32'd0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_inst_q    <= rsp_inst_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_fault_q   <= rsp_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_inst    = rsp_inst_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_fault   = rsp_fault_q;
  assign fetch_count = fetch_count_q;

endmodule
